// File: rtl/dab_mod_sequencer.sv
// DAB modulation sequencer: samples Vdc1/Vdc2/Iref on trigger and computes tau1, tau2, phi
// with a single shared restoring divider, then registers saturated results on out_valid.
module dab_mod_sequencer #(
    parameter int W_IN       = 14,
    parameter int W_OUT      = 9,
    parameter int RATIO      = 704,
    parameter int RATIO_FRAC = 7,
    parameter int K_PHI      = 1000,
    parameter int PHI_MAX    = 127
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    trigger,
    input  logic signed [W_IN-1:0]  Vdc1,
    input  logic signed [W_IN-1:0]  Vdc2,
    input  logic signed [W_IN-1:0]  Iref,
    output logic signed [W_OUT-1:0] tau1,
    output logic signed [W_OUT-1:0] tau2,
    output logic signed [W_OUT-1:0] phi,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    overrun,
    output logic                    vzero_fault
);

    localparam int VW      = W_IN + 16;
    localparam int DW      = VW + W_OUT;
    localparam int QW      = W_OUT - 1;
    localparam int CW      = $clog2(W_OUT);
    localparam int PI_CODE = 2**(W_OUT-1) - 1;
    localparam logic signed [W_OUT-1:0] PI_TAU   = W_OUT'(PI_CODE);
    localparam logic [QW-1:0]           PHI_LIM  = QW'(PHI_MAX);
    localparam logic [CW-1:0]           CNT_LAST = CW'(QW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCALE,
        S_DIV_DUTY,
        S_DIV_PHI,
        S_UPDATE
    } state_t;

    function automatic logic [QW-1:0] sat_mag(input logic [QW-1:0] q);
        return (q > PHI_LIM) ? PHI_LIM : q;
    endfunction

    state_t                    state_q, state_d;
    logic signed [W_OUT-1:0]   tau1_q, tau1_d, tau2_q, tau2_d, phi_q, phi_d;
    logic                      out_valid_q, out_valid_d;
    logic                      overrun_q, overrun_d;
    logic                      vzero_q, vzero_d;

    logic signed [W_IN-1:0]    vdc1_q, vdc1_d, vdc2_q, vdc2_d, iref_q, iref_d;
    logic [VW-1:0]             vmax_q, vmax_d, num_phi_q, num_phi_d;
    logic                      neg_q, neg_d, buck_q, buck_d, boost_q, boost_d;
    logic [DW-1:0]             rem_q, rem_d, div_q, div_d;
    logic [QW-1:0]             quo_q, quo_d, duty_q, duty_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      ovf_q, ovf_d;

    logic [VW-1:0]             v1_c, v2_ext_c, v2p_prod_c, v2p_c, vmax_c, vmin_c, num_phi_c;
    logic [W_IN:0]             iref_ext_c, iref_abs_c;
    logic                      ge_c;
    logic [DW-1:0]             rem_step_c;
    logic [QW-1:0]             quo_step_c, q_fin_c, mag_c;
    logic signed [W_OUT-1:0]   phi_c, duty_tau_c;

    // Negative bus voltages are clamped to zero before scaling.
    assign v1_c       = vdc1_q[W_IN-1] ? '0 : VW'($unsigned(vdc1_q));
    assign v2_ext_c   = vdc2_q[W_IN-1] ? '0 : VW'($unsigned(vdc2_q));
    assign v2p_prod_c = v2_ext_c * VW'(RATIO);
    assign v2p_c      = v2p_prod_c >> RATIO_FRAC;
    assign vmax_c     = (v1_c > v2p_c) ? v1_c : v2p_c;
    assign vmin_c     = (v1_c > v2p_c) ? v2p_c : v1_c;
    // One extra bit so that |-2^(W_IN-1)| is exact.
    assign iref_ext_c = {iref_q[W_IN-1], iref_q};
    assign iref_abs_c = iref_q[W_IN-1] ? (~iref_ext_c + (W_IN+1)'(1)) : iref_ext_c;
    assign num_phi_c  = VW'(iref_abs_c) * VW'(K_PHI);

    assign ge_c       = (rem_q >= div_q);
    assign rem_step_c = ge_c ? (rem_q - div_q) : rem_q;
    assign quo_step_c = {quo_q[QW-2:0], ge_c};
    assign q_fin_c    = ovf_q ? '1 : quo_step_c;
    assign mag_c      = sat_mag(q_fin_c);
    assign phi_c      = neg_q ? -$signed({1'b0, mag_c}) : $signed({1'b0, mag_c});
    assign duty_tau_c = $signed({1'b0, duty_q});

    always_comb begin
        state_d     = state_q;
        tau1_d      = tau1_q;
        tau2_d      = tau2_q;
        phi_d       = phi_q;
        out_valid_d = 1'b0;
        vzero_d     = vzero_q;
        overrun_d   = trigger && (state_q != S_IDLE);
        vdc1_d      = vdc1_q;
        vdc2_d      = vdc2_q;
        iref_d      = iref_q;
        vmax_d      = vmax_q;
        num_phi_d   = num_phi_q;
        neg_d       = neg_q;
        buck_d      = buck_q;
        boost_d     = boost_q;
        rem_d       = rem_q;
        div_d       = div_q;
        quo_d       = quo_q;
        duty_d      = duty_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    vdc1_d  = Vdc1;
                    vdc2_d  = Vdc2;
                    iref_d  = Iref;
                    state_d = S_SCALE;
                end
            end
            S_SCALE: begin
                vmax_d    = vmax_c;
                num_phi_d = num_phi_c;
                neg_d     = iref_q[W_IN-1];
                buck_d    = v1_c > v2p_c;
                boost_d   = v2p_c > v1_c;
                rem_d     = DW'(PI_CODE) * DW'(vmin_c);
                div_d     = DW'(vmax_c) << (QW - 1);
                quo_d     = '0;
                cnt_d     = '0;
                state_d   = S_DIV_DUTY;
            end
            S_DIV_DUTY: begin
                rem_d = rem_step_c;
                div_d = div_q >> 1;
                quo_d = quo_step_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // Reload the shared divider for the phase quotient.
                    duty_d  = quo_step_c;
                    rem_d   = DW'(num_phi_q);
                    div_d   = DW'(vmax_q) << (QW - 1);
                    quo_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = DW'(num_phi_q) >= (DW'(vmax_q) << QW);
                    state_d = S_DIV_PHI;
                end
            end
            S_DIV_PHI: begin
                rem_d = rem_step_c;
                div_d = div_q >> 1;
                quo_d = quo_step_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    out_valid_d = 1'b1;
                    state_d     = S_UPDATE;
                    if (vmax_q == '0) begin
                        tau1_d  = PI_TAU;
                        tau2_d  = PI_TAU;
                        phi_d   = '0;
                        vzero_d = 1'b1;
                    end else begin
                        tau1_d  = buck_q ? duty_tau_c : PI_TAU;
                        tau2_d  = boost_q ? duty_tau_c : PI_TAU;
                        phi_d   = phi_c;
                        vzero_d = 1'b0;
                    end
                end
            end
            S_UPDATE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tau1_q      <= '0;
            tau2_q      <= '0;
            phi_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            vzero_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tau1_q      <= tau1_d;
            tau2_q      <= tau2_d;
            phi_q       <= phi_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            vzero_q     <= vzero_d;
        end
    end

    // Datapath registers carry no reset; the FSM never consumes them before loading them.
    always_ff @(posedge clk) begin
        vdc1_q    <= vdc1_d;
        vdc2_q    <= vdc2_d;
        iref_q    <= iref_d;
        vmax_q    <= vmax_d;
        num_phi_q <= num_phi_d;
        neg_q     <= neg_d;
        buck_q    <= buck_d;
        boost_q   <= boost_d;
        rem_q     <= rem_d;
        div_q     <= div_d;
        quo_q     <= quo_d;
        duty_q    <= duty_d;
        cnt_q     <= cnt_d;
        ovf_q     <= ovf_d;
    end

    assign tau1        = tau1_q;
    assign tau2        = tau2_q;
    assign phi         = phi_q;
    assign out_valid   = out_valid_q;
    assign overrun     = overrun_q;
    assign vzero_fault = vzero_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_dab_mod_sequencer.sv
// Self-checking bench for dab_mod_sequencer: directed spec vectors, randomized samples against
// an arithmetic reference model, overrun, mid-computation reset and back-to-back triggers.
module tb_dab_mod_sequencer;

    localparam int RATIO   = 704;
    localparam int RFRAC   = 7;
    localparam int K_PHI   = 1000;
    localparam int PHI_MAX = 127;
    localparam int PI_CODE = 255;
    localparam int LAT     = 18;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              trigger = 1'b0;
    logic signed [13:0] vdc1 = '0, vdc2 = '0, iref = '0;
    logic signed [8:0]  tau1, tau2, phi;
    logic              out_valid, busy, overrun, vzero_fault;

    int n_vec = 0;
    int n_err = 0;

    dab_mod_sequencer dut (
        .clk(clk), .rst(rst), .trigger(trigger),
        .Vdc1(vdc1), .Vdc2(vdc2), .Iref(iref),
        .tau1(tau1), .tau2(tau2), .phi(phi),
        .out_valid(out_valid), .busy(busy), .overrun(overrun), .vzero_fault(vzero_fault)
    );

    always #5 clk = ~clk;

    function automatic void model(input int a, input int b, input int c,
                                  output int t1, output int t2, output int ph, output int vz);
        longint v1, v2p, vmax, vmin, nphi, q, mag, duty;
        v1   = (a < 0) ? 0 : a;
        v2p  = (((b < 0) ? 0 : b) * RATIO) / (2 ** RFRAC);
        vmax = (v1 > v2p) ? v1 : v2p;
        vmin = (v1 > v2p) ? v2p : v1;
        if (vmax == 0) begin
            t1 = PI_CODE; t2 = PI_CODE; ph = 0; vz = 1;
            return;
        end
        duty = (PI_CODE * vmin) / vmax;
        if (v1 == v2p) begin t1 = PI_CODE; t2 = PI_CODE; end
        else if (v1 > v2p) begin t1 = int'(duty); t2 = PI_CODE; end
        else begin t1 = PI_CODE; t2 = int'(duty); end
        nphi = K_PHI * ((c < 0) ? -c : c);
        q    = (nphi >= vmax * 256) ? 255 : nphi / vmax;
        mag  = (q > PHI_MAX) ? PHI_MAX : q;
        ph   = (c < 0) ? -int'(mag) : int'(mag);
        vz   = 0;
    endfunction

    // Drive one trigger, scramble the inputs after acceptance, wait (bounded) for out_valid.
    task automatic fire(input int a, input int b, input int c, output int lat);
        @(posedge clk); #1;
        vdc1 = 14'(a); vdc2 = 14'(b); iref = 14'(c); trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        vdc1 = 14'($urandom); vdc2 = 14'($urandom); iref = 14'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({tau1, tau2, phi} !== 27'd0 || {out_valid, busy, overrun, vzero_fault} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_state: tau1=%0d tau2=%0d phi=%0d flags=%b required all 0",
                     tau1, tau2, phi, {out_valid, busy, overrun, vzero_fault});
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        int a[8]  = '{5500, 5500, 100, -50, 0, 100, 1000, 125};
        int b[8]  = '{1000, 500, 0, 0, 0, 200, 0, 0};
        int c[8]  = '{0, -11, 8191, 100, 500, 5, -8192, 32};
        int e1[8] = '{255, 127, 0, 255, 255, 255, 0, 0};
        int e2[8] = '{255, 255, 255, 255, 255, 23, 255, 255};
        int ep[8] = '{0, -2, 127, 0, 0, 4, -127, 127};
        int ez[8] = '{0, 0, 0, 1, 1, 0, 0, 0};
        int lat;
        logic signed [8:0] x1, x2, xp;
        for (int i = 0; i < 8; i++) begin
            fire(a[i], b[i], c[i], lat);
            x1 = 9'(e1[i]); x2 = 9'(e2[i]); xp = 9'(ep[i]);
            n_vec++;
            if (lat !== LAT) begin
                n_err++;
                $display("FAIL dir%0d_latency: got %0d cycles required %0d", i, lat, LAT);
            end
            n_vec++;
            if (tau1 !== x1 || tau2 !== x2 || phi !== xp || vzero_fault !== ez[i][0]) begin
                n_err++;
                $display("FAIL dir%0d_result: got tau1=%0d tau2=%0d phi=%0d vz=%b required %0d %0d %0d %0d",
                         i, tau1, tau2, phi, vzero_fault, x1, x2, xp, ez[i]);
            end
            @(posedge clk); #1;
            n_vec++;
            if (out_valid !== 1'b0 || tau1 !== x1 || phi !== xp || busy !== 1'b0) begin
                n_err++;
                $display("FAIL dir%0d_hold: got out_valid=%b busy=%b tau1=%0d phi=%0d required 0 0 %0d %0d",
                         i, out_valid, busy, tau1, phi, x1, xp);
            end
        end
    endtask

    task automatic test_random();
        int a, b, c, lat, t1, t2, ph, vz;
        logic signed [13:0] r;
        for (int i = 0; i < 40; i++) begin
            r = 14'($urandom); a = r;
            if (i % 2 == 0) begin
                b = ((a < 0) ? 0 : a) * 128 / RATIO + $urandom_range(0, 6) - 3;
            end else begin
                r = 14'($urandom); b = r;
            end
            r = 14'($urandom); c = (i % 3 == 0) ? (r % 200) : int'(r);
            model(a, b, c, t1, t2, ph, vz);
            fire(a, b, c, lat);
            n_vec++;
            if (lat !== LAT || tau1 !== 9'(t1) || tau2 !== 9'(t2) || phi !== 9'(ph) || vzero_fault !== vz[0]) begin
                n_err++;
                $display("FAIL rand%0d (%0d,%0d,%0d): got lat=%0d tau1=%0d tau2=%0d phi=%0d vz=%b required %0d %0d %0d %0d %0d",
                         i, a, b, c, lat, tau1, tau2, phi, vzero_fault, LAT, t1, t2, ph, vz);
            end
        end
    endtask

    task automatic test_overrun();
        int t1, t2, ph, vz, lat;
        bit seen;
        model(5500, 500, -11, t1, t2, ph, vz);
        @(posedge clk); #1;
        n_vec++;
        if (busy !== 1'b0 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_idle: got busy=%b overrun=%b required 0 0", busy, overrun);
        end
        vdc1 = 14'(5500); vdc2 = 14'(500); iref = -14'sd11; trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_cycle1: got busy=%b overrun=%b required 1 0", busy, overrun);
        end
        repeat (4) begin @(posedge clk); #1; end
        vdc1 = 14'(100); vdc2 = 14'(0); iref = 14'(8191); trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        n_vec++;
        if (overrun !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_pulse: got overrun=%b at cycle 6 required 1", overrun);
        end
        @(posedge clk); #1;
        n_vec++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_width: got overrun=%b at cycle 7 required 0", overrun);
        end
        lat = 7;
        while (out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        n_vec++;
        if (lat !== LAT || tau1 !== 9'(t1) || tau2 !== 9'(t2) || phi !== 9'(ph)) begin
            n_err++;
            $display("FAIL ovr_result: got lat=%0d tau1=%0d tau2=%0d phi=%0d required %0d %0d %0d %0d",
                     lat, tau1, tau2, phi, LAT, t1, t2, ph);
        end
        seen = 1'b0;
        repeat (25) begin @(posedge clk); #1; if (out_valid === 1'b1) seen = 1'b1; end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_single: got a second out_valid required none");
        end
    endtask

    task automatic test_reset_midway();
        int t1, t2, ph, vz, lat;
        bit seen;
        @(posedge clk); #1;
        vdc1 = 14'(5500); vdc2 = 14'(500); iref = 14'(3000); trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({tau1, tau2, phi} !== 27'd0 || {out_valid, busy, overrun, vzero_fault} !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_mid: got tau1=%0d tau2=%0d phi=%0d flags=%b required all 0",
                     tau1, tau2, phi, {out_valid, busy, overrun, vzero_fault});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (25) begin @(posedge clk); #1; if (out_valid === 1'b1) seen = 1'b1; end
        n_vec++;
        if (seen !== 1'b0 || tau1 !== 9'sd0) begin
            n_err++;
            $display("FAIL rst_discard: got out_valid_seen=%b tau1=%0d required 0 0", seen, tau1);
        end
        model(100, 200, 5, t1, t2, ph, vz);
        fire(100, 200, 5, lat);
        n_vec++;
        if (lat !== LAT || tau1 !== 9'(t1) || tau2 !== 9'(t2) || phi !== 9'(ph) || vzero_fault !== vz[0]) begin
            n_err++;
            $display("FAIL rst_recover: got lat=%0d tau1=%0d tau2=%0d phi=%0d required %0d %0d %0d %0d",
                     lat, tau1, tau2, phi, LAT, t1, t2, ph);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2, ph, vz, lat;
        fire(5500, 1000, 0, lat);
        n_vec++;
        if (lat !== LAT || tau1 !== 9'sd255 || tau2 !== 9'sd255 || phi !== 9'sd0) begin
            n_err++;
            $display("FAIL b2b_first: got lat=%0d tau1=%0d tau2=%0d phi=%0d required %0d 255 255 0",
                     lat, tau1, tau2, phi, LAT);
        end
        vdc1 = 14'(100); vdc2 = 14'(0); iref = 14'(8191); trigger = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (overrun !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_update_trig: got overrun=%b out_valid=%b required 1 0", overrun, out_valid);
        end
        model(1000, 0, -8192, t1, t2, ph, vz);
        vdc1 = 14'(1000); vdc2 = 14'(0); iref = -14'sd8192;
        @(posedge clk); #1;
        trigger = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_accept: got busy=%b overrun=%b required 1 0", busy, overrun);
        end
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        n_vec++;
        if (lat !== LAT || tau1 !== 9'(t1) || tau2 !== 9'(t2) || phi !== 9'(ph)) begin
            n_err++;
            $display("FAIL b2b_second: got lat=%0d tau1=%0d tau2=%0d phi=%0d required %0d %0d %0d %0d",
                     lat, tau1, tau2, phi, LAT, t1, t2, ph);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_overrun();
        test_reset_midway();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
